ref_row_fetcher: RTL and testbench
==================================

// Module: ref_row_fetcher
// PURPOSE
//  Source end of the subpixel interpolator's row interface. Reads a 15x15-pixel
//  reference window (8x8 block + 7 filter-tap border) from word-organised frame
//  memory and streams it one 120-bit row at a time into in_row. Handles a
//  window start that is not word-aligned. Handshake is valid/ready.
// PARAMETERS
//  PIX_W     8   bits per pixel
//  ROW_PIX   15  pixels per output row (8 + 7 taps)
//  NUM_ROWS  15  rows per window
//  WORD_PIX  8   pixels per memory word (memory word = 64 bits)
//  ADDR_W    16  memory word-address width
// PORTS
//  clk          in   1                clock, all logic on rising edge
//  rst          in   1                synchronous, active-high reset
//  start        in   1                begin a window; sampled only in IDLE
//  start_word   in   ADDR_W           word address of the word holding the top-left pixel
//  start_off    in   3                pixel offset of the top-left pixel in that word (0..7)
//  stride       in   ADDR_W           frame line pitch, in words
//  mem_rd       out  1                memory read strobe
//  mem_addr     out  ADDR_W           memory word address
//  mem_rdata    in   WORD_PIX*PIX_W   read data, valid exactly 1 cycle after mem_rd
//  in_row       out  ROW_PIX*PIX_W    row pixels; pixel i at [8i+7:8i]
//  row_valid    out  1                in_row holds a valid row
//  row_ready    in   1                consumer accepts the row
//  row_idx      out  4                index (0..14) of the row on in_row
//  busy         out  1                high from the cycle after start until done
//  done         out  1                one-cycle pulse after the last row is accepted
// BEHAVIOUR
//  - Reset: state IDLE. mem_rd=0, mem_addr=0, in_row=0, row_valid=0,
//    row_idx=0, busy=0, done=0. The 24-pixel assembly buffer is cleared.
//  - FSM: IDLE -> RD0 -> RD1 -> RD2 -> CAP -> OUT -> (RD0 | FIN) -> IDLE.
//    * IDLE: on start=1, latch start_word, start_off and stride.
//      Set row_base = start_word and row = 0. Next state is RD0.
//    * RD0/RD1/RD2: drive mem_rd=1 with mem_addr = row_base + k, k = 0/1/2.
//      RD1 captures word0, RD2 captures word1, CAP captures word2 (mem_rd=0 in CAP).
//    * Memory word pixel j is at mem_rdata[8j+7:8j]. Word k fills buffer pixels 8k..8k+7.
//    * CAP -> OUT: load in_row = buffer pixels [off .. off+14]. off+14 <= 21 < 24,
//      so three words always suffice.
//    * OUT: row_valid=1. in_row and row_idx are held stable until row_ready=1.
//      On accept: row_valid drops next cycle, row_base += stride, row++.
//      If the accepted row was 14, go to FIN; otherwise go to RD0.
//    * FIN: done=1 for one cycle, busy=0 from the next cycle. Next state is IDLE.
//  - Latency: start sampled at edge T gives first row_valid in cycle T+5.
//    Steady state (row_ready held high) delivers 1 row per 5 cycles, 75 cycles per window.
//  - Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
//  - start while not IDLE is ignored; latched parameters do not change mid-window.
//  - row_ready while row_valid=0 has no effect.
//  - rst mid-window aborts immediately to the reset state. No done pulse is produced.
//  - row_valid=1 and row_ready=1 in the same cycle counts as exactly one accept.
// TESTING
//  1. Aligned fetch: memory word w holds bytes {w[7:0]+j}. Use start_word=0x100,
//     off=0, stride=0x20. Row r is read at 0x100+0x20r..+2. Row 0 in_row bytes =
//     0x00..0x07, 0x01..0x07 pattern per word. done is seen exactly 75 cycles
//     after the start edge with ready tied high.
//  2. Unaligned: off=7. Row r pixel 0 = word0 byte 7 and pixel 14 = word2 byte 5.
//     Repeat for off=1..6 and check every pixel against the reference model.
//  3. Backpressure: row_ready low for 10 cycles on row 3. in_row and row_idx=3
//     stay stable; no mem_rd is issued; row 4 reads begin the cycle after accept.
//  4. Address wrap: start_word=0xFFFE, stride=1. Row 0 reads 0xFFFE, 0xFFFF, 0x0000;
//     row 1 reads 0xFFFF, 0x0000, 0x0001.
//  5. start pulsed during row 5 -> ignored. Reset asserted at row 8 -> all outputs
//     return to reset values next cycle, no done. A new start then runs a full
//     clean window.
//  6. Back-to-back windows: start held high. The second window begins 1 cycle after
//     FIN and uses parameters sampled in that IDLE cycle.

Source files
------------

// File: rtl/ref_row_fetcher_if.sv
// ----------------------------------------------------------------------------
// ref_row_fetcher_if
//  Bundles the two buses of the reference row fetcher:
//   * frame-memory read port : mem_rd, mem_addr (fetcher -> memory),
//                              mem_rdata (memory -> fetcher, 1 cycle after mem_rd)
//   * row stream             : in_row, row_valid, row_idx (fetcher -> consumer),
//                              row_ready (consumer -> fetcher)
//  master = fetcher side, slave = memory + interpolator side.
// ----------------------------------------------------------------------------
interface ref_row_fetcher_if #(
    parameter int PIX_W    = 8,
    parameter int ROW_PIX  = 15,
    parameter int WORD_PIX = 8,
    parameter int ADDR_W   = 16
) ();
    logic                        mem_rd;
    logic [ADDR_W-1:0]           mem_addr;
    logic [WORD_PIX*PIX_W-1:0]   mem_rdata;
    logic [ROW_PIX*PIX_W-1:0]    in_row;
    logic                        row_valid;
    logic                        row_ready;
    logic [3:0]                  row_idx;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdata,
        output in_row,
        output row_valid,
        output row_idx,
        input  row_ready
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdata,
        input  in_row,
        input  row_valid,
        input  row_idx,
        output row_ready
    );
endinterface

// File: rtl/ref_row_fetcher.sv
// ----------------------------------------------------------------------------
// ref_row_fetcher
//  Source end of the subpixel interpolator row interface. Fetches a
//  ROW_PIX x NUM_ROWS reference window from word-organised frame memory and
//  streams it one row at a time. Each row needs three consecutive memory words
//  because the window start may sit at any pixel offset inside a word.
//
// Ports
//  clk, rst     clock and synchronous active-high reset
//  start        begin a window (only looked at while idle)
//  start_word   word address holding the top-left pixel
//  start_off    pixel offset of the top-left pixel inside that word
//  stride       frame line pitch in words
//  bus          ref_row_fetcher_if.master: memory read port + row stream
//  busy         high from the cycle after start until the window finishes
//  done         one-cycle pulse after the last row is accepted
//
// Per-row schedule (5 cycles with row_ready held high):
//  RD0  mem_rd, addr = base+0
//  RD1  mem_rd, addr = base+1, word0 arrives and is captured
//  RD2  mem_rd, addr = base+2, word1 arrives and is captured
//  CAP  word2 arrives; the output row is extracted from all three words
//  OUT  row_valid held until row_ready
// ----------------------------------------------------------------------------
module ref_row_fetcher #(
    parameter int PIX_W    = 8,
    parameter int ROW_PIX  = 15,
    parameter int NUM_ROWS = 15,
    parameter int WORD_PIX = 8,
    parameter int ADDR_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_word,
    input  logic [2:0]            start_off,
    input  logic [ADDR_W-1:0]     stride,
    ref_row_fetcher_if.master     bus,
    output logic                  busy,
    output logic                  done
);

    localparam int WORD_W = WORD_PIX * PIX_W;
    localparam int ROW_W  = ROW_PIX * PIX_W;
    localparam int BUF_W  = 3 * WORD_W;

    localparam logic [3:0]        LAST_ROW = 4'(NUM_ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] ADDR_TWO = ADDR_W'(2'd2);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_CAP  = 3'd4,
        ST_OUT  = 3'd5,
        ST_FIN  = 3'd6
    } state_t;

    state_t                state_r;
    logic [ADDR_W-1:0]     row_base_r;
    logic [ADDR_W-1:0]     stride_r;
    logic [2:0]            off_r;
    logic [3:0]            row_r;
    logic [BUF_W-1:0]      asm_buf_r;

    logic                  mem_rd_r;
    logic [ADDR_W-1:0]     mem_addr_r;
    logic [ROW_W-1:0]      in_row_r;
    logic                  row_valid_r;
    logic [3:0]            row_idx_r;
    logic                  busy_r;
    logic                  done_r;

    logic [BUF_W-1:0]      buf_next_s;
    logic [7:0]            shamt_s;
    logic [BUF_W-1:0]      shifted_s;
    logic [ROW_W-1:0]      sel_row_s;

    // Row extraction: word2 is still on mem_rdata during CAP, so the window
    // is taken from the buffer as it will look after this cycle's capture.
    always_comb begin
        buf_next_s = {bus.mem_rdata, asm_buf_r[2*WORD_W-1:0]};
        shamt_s    = 8'(off_r) * 8'(PIX_W);
        shifted_s  = buf_next_s >> shamt_s;
        sel_row_s  = shifted_s[ROW_W-1:0];
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            row_base_r  <= {ADDR_W{1'b0}};
            stride_r    <= {ADDR_W{1'b0}};
            off_r       <= 3'd0;
            row_r       <= 4'd0;
            asm_buf_r   <= {BUF_W{1'b0}};
            mem_rd_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            in_row_r    <= {ROW_W{1'b0}};
            row_valid_r <= 1'b0;
            row_idx_r   <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        row_base_r <= start_word;
                        stride_r   <= stride;
                        off_r      <= start_off;
                        row_r      <= 4'd0;
                        busy_r     <= 1'b1;
                        mem_rd_r   <= 1'b1;
                        mem_addr_r <= start_word;
                        state_r    <= ST_RD0;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end

                ST_RD0: begin
                    mem_addr_r <= row_base_r + ADDR_ONE;
                    state_r    <= ST_RD1;
                end

                ST_RD1: begin
                    asm_buf_r[WORD_W-1:0] <= bus.mem_rdata;
                    mem_addr_r            <= row_base_r + ADDR_TWO;
                    state_r               <= ST_RD2;
                end

                ST_RD2: begin
                    asm_buf_r[2*WORD_W-1:WORD_W] <= bus.mem_rdata;
                    mem_rd_r                     <= 1'b0;
                    state_r                      <= ST_CAP;
                end

                ST_CAP: begin
                    asm_buf_r[3*WORD_W-1:2*WORD_W] <= bus.mem_rdata;
                    in_row_r                       <= sel_row_s;
                    row_idx_r                      <= row_r;
                    row_valid_r                    <= 1'b1;
                    state_r                        <= ST_OUT;
                end

                ST_OUT: begin
                    // in_row/row_idx are left untouched while the row waits.
                    if (bus.row_ready) begin
                        row_valid_r <= 1'b0;
                        row_base_r  <= row_base_r + stride_r;
                        row_r       <= row_r + 4'd1;
                        if (row_r == LAST_ROW) begin
                            done_r  <= 1'b1;
                            state_r <= ST_FIN;
                        end else begin
                            mem_rd_r   <= 1'b1;
                            mem_addr_r <= row_base_r + stride_r;
                            state_r    <= ST_RD0;
                        end
                    end else begin
                        state_r <= ST_OUT;
                    end
                end

                ST_FIN: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    mem_rd_r    <= 1'b0;
                    row_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd    = mem_rd_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.in_row    = in_row_r;
    assign bus.row_valid = row_valid_r;
    assign bus.row_idx   = row_idx_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_ref_row_fetcher.sv
// ----------------------------------------------------------------------------
// tb_ref_row_fetcher
//  Scoreboard bench: each started window pushes its expected memory reads and
//  rows into queues; monitors pop and compare on mem_rd and on row accepts.
//  Memory model: word w holds bytes (w[7:0] + j) at pixel position j.
// ----------------------------------------------------------------------------
module tb_ref_row_fetcher;

    localparam int ROW_W = 120;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] start_word;
    logic [2:0]  start_off;
    logic [15:0] stride;
    logic        busy;
    logic        done;

    ref_row_fetcher_if #(.PIX_W(8), .ROW_PIX(15), .WORD_PIX(8), .ADDR_W(16)) bus ();

    ref_row_fetcher #(
        .PIX_W(8), .ROW_PIX(15), .NUM_ROWS(15), .WORD_PIX(8), .ADDR_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_word (start_word),
        .start_off  (start_off),
        .stride     (stride),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0]      q_addr[$];
    logic [ROW_W-1:0] q_row[$];
    logic [3:0]       q_idx[$];

    function automatic logic [63:0] mk_word(input logic [15:0] a);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[8*j +: 8] = a[7:0] + 8'(j);
        return w;
    endfunction

    function automatic logic [ROW_W-1:0] exp_row(input logic [15:0] rb, input int off);
        logic [ROW_W-1:0] r;
        int               p;
        logic [15:0]      a;
        r = '0;
        for (int i = 0; i < 15; i++) begin
            p = off + i;
            a = rb + 16'(p / 8);
            r[8*i +: 8] = a[7:0] + 8'(p % 8);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: data valid the cycle after mem_rd.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mk_word(bus.mem_addr);
    end

    // Monitor: compares every memory read and every accepted row.
    always @(negedge clk) begin
        logic [15:0] ea;
        if (!rst) begin
            if (bus.mem_rd) begin
                if (q_addr.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL mem_addr: unexpected read of %h, none expected", bus.mem_addr);
                end else begin
                    ea = q_addr.pop_front();
                    chk("mem_addr", {112'd0, bus.mem_addr}, {112'd0, ea});
                end
            end
            if (bus.row_valid && bus.row_ready) begin
                if (q_row.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL row: unexpected row idx %0d, none expected", bus.row_idx);
                end else begin
                    chk("in_row", {8'd0, bus.in_row}, {8'd0, q_row.pop_front()});
                    chk("row_idx", {124'd0, bus.row_idx}, {124'd0, q_idx.pop_front()});
                end
            end
        end
    end

    task automatic push_window(input logic [15:0] sw, input logic [2:0] so, input logic [15:0] st);
        logic [15:0] rb;
        rb = sw;
        for (int r = 0; r < 15; r++) begin
            q_addr.push_back(rb);
            q_addr.push_back(rb + 16'd1);
            q_addr.push_back(rb + 16'd2);
            q_row.push_back(exp_row(rb, int'(so)));
            q_idx.push_back(4'(r));
            rb = rb + st;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the start edge.
    task automatic start_window(input logic [15:0] sw, input logic [2:0] so, input logic [15:0] st);
        push_window(sw, so, st);
        start_word = sw; start_off = so; stride = st; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {127'd0, busy}, 128'd1);
    endtask

    // Counts cycles after the start edge until done is observed (bounded).
    task automatic wait_done(output int cyc);
        int found;
        cyc = 0; found = 0;
        while (cyc < 400 && found == 0) begin
            @(posedge clk); #1;
            cyc++;
            if (done) found = 1;
        end
        if (found == 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 400 cycles");
        end
    endtask

    task automatic finish_window();
        @(posedge clk); #1;
        chk("busy_idle", {127'd0, busy}, 128'd0);
        chk("done_pulse", {127'd0, done}, 128'd0);
    endtask

    task automatic wait_valid_idx(input logic [3:0] idx);
        int n;
        n = 0;
        while (n < 200 && !(bus.row_valid && bus.row_idx == idx)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL row_wait: got no row %0d expected it within 200 cycles", idx);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_rd", {127'd0, bus.mem_rd}, 128'd0);
        chk("rst_mem_addr", {112'd0, bus.mem_addr}, 128'd0);
        chk("rst_in_row", {8'd0, bus.in_row}, 128'd0);
        chk("rst_row_valid", {127'd0, bus.row_valid}, 128'd0);
        chk("rst_row_idx", {124'd0, bus.row_idx}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; start_word = 16'd0; start_off = 3'd0; stride = 16'd0;
        bus.row_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk); #1;

        // 1. aligned window, done exactly 75 cycles after start edge
        start_window(16'h0100, 3'd0, 16'h0020);
        wait_done(cyc);
        chk("done_latency", 128'(cyc), 128'd75);
        finish_window();

        // 2. every non-zero offset
        for (int o = 1; o < 8; o++) begin
            start_window(16'h02A0 + 16'(o * 17), 3'(o), 16'h0013);
            wait_done(cyc);
            finish_window();
        end

        // 3. backpressure on row 3
        start_window(16'h0400, 3'd2, 16'h0030);
        wait_valid_idx(4'd2);
        @(posedge clk); #1;
        bus.row_ready = 1'b0;
        wait_valid_idx(4'd3);
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_row_valid", {127'd0, bus.row_valid}, 128'd1);
            chk("bp_row_idx", {124'd0, bus.row_idx}, 128'd3);
            chk("bp_in_row", {8'd0, bus.in_row}, {8'd0, exp_row(16'h0400 + 16'h0090, 2)});
            chk("bp_no_mem_rd", {127'd0, bus.mem_rd}, 128'd0);
        end
        bus.row_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_drop", {127'd0, bus.row_valid}, 128'd0);
        chk("bp_row4_rd", {127'd0, bus.mem_rd}, 128'd1);
        chk("bp_row4_addr", {112'd0, bus.mem_addr}, {112'd0, 16'h04C0});
        wait_done(cyc);
        finish_window();

        // 4. address wrap-around
        start_window(16'hFFFE, 3'd3, 16'h0001);
        wait_done(cyc);
        finish_window();

        // 5. ignored start mid-window, then reset abort at row 8
        start_window(16'h0800, 3'd5, 16'h0040);
        wait_valid_idx(4'd5);
        @(posedge clk); #1;
        start = 1'b1; start_word = 16'h1234; start_off = 3'd1; stride = 16'h0007;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid_idx(4'd8);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs();
        rst = 1'b0;
        q_addr.delete(); q_row.delete(); q_idx.delete();
        repeat (5) begin
            @(posedge clk); #1;
            chk("no_done_after_abort", {127'd0, done}, 128'd0);
        end
        start_window(16'h0A00, 3'd4, 16'h0021);
        wait_done(cyc);
        chk("clean_latency", 128'(cyc), 128'd75);
        finish_window();

        // 6. back-to-back windows with start held high
        push_window(16'h0C00, 3'd6, 16'h0010);
        push_window(16'h0D00, 3'd1, 16'h0011);
        start_word = 16'h0C00; start_off = 3'd6; stride = 16'h0010; start = 1'b1;
        @(posedge clk); #1;
        start_word = 16'h0D00; start_off = 3'd1; stride = 16'h0011;
        wait_done(cyc);
        chk("b2b_first_latency", 128'(cyc), 128'd75);
        @(posedge clk); #1;
        chk("b2b_idle_no_rd", {127'd0, bus.mem_rd}, 128'd0);
        chk("b2b_idle_busy", {127'd0, busy}, 128'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_second_rd", {127'd0, bus.mem_rd}, 128'd1);
        chk("b2b_second_addr", {112'd0, bus.mem_addr}, {112'd0, 16'h0D00});
        chk("b2b_second_busy", {127'd0, busy}, 128'd1);
        wait_done(cyc);
        chk("b2b_second_latency", 128'(cyc), 128'd75);
        finish_window();

        repeat (3) @(posedge clk);
        #1;
        chk("addr_queue_empty", 128'(q_addr.size()), 128'd0);
        chk("row_queue_empty", 128'(q_row.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
